// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM state encoding,
// ALU opcodes and a small one-hot helper.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_INC = 3'b000,  // A + cin (transfer when cin=0)
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,  // A + ~B + cin
        OP_DEC = 3'b011,  // A - 1 + cin (transfer when cin=1)
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_NOT = 3'b111
    } alu_op_e;

    function automatic logic [1:0] onehot2(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU; arithmetic wraps modulo 2^WIDTH and no carry-out is
// produced.
module alu
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    input  logic             cin,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] cin_ext;
    assign cin_ext = WIDTH'(cin);

    always_comb begin
        y = '0;
        case (op)
            OP_INC:  y = a + cin_ext;
            OP_ADD:  y = a + b + cin_ext;
            OP_SUB:  y = a + ~b + cin_ext;
            OP_DEC:  y = a + {WIDTH{1'b1}} + cin_ext;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOT:  y = ~a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; each operation
// runs IDLE (accept) -> EXEC (compute) -> RESP (hold until owner handshake).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [2:0]       req_op0,
    input  logic [2:0]       req_op1,
    input  logic             req_cin0,
    input  logic             req_cin1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             busy
);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    alu_op_e          op_q, op_d;
    logic             cin_q, cin_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] alu_y;
    logic             winner;
    logic [1:0]       ready_int;

    always_comb begin
        case (req_valid)
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_grant_q;
            default: winner = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        cin_d        = cin_q;
        result_d     = result_q;
        zero_d       = zero_q;
        ready_int    = 2'b00;
        rsp_valid    = 2'b00;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    ready_int    = onehot2(winner);
                    state_d      = EXEC;
                    owner_d      = winner;
                    last_grant_d = winner;
                    a_d          = winner ? req_a1 : req_a0;
                    b_d          = winner ? req_b1 : req_b0;
                    op_d         = alu_op_e'(winner ? req_op1 : req_op0);
                    cin_d        = winner ? req_cin1 : req_cin0;
                end
            end
            EXEC: begin
                result_d = alu_y;
                zero_d   = (alu_y == '0);
                state_d  = RESP;
            end
            RESP: begin
                rsp_valid = onehot2(owner_q);
                // Only the owner's ready completes the handshake.
                if (rsp_ready[owner_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready must stay low while reset is held even though state already reads IDLE.
    assign req_ready  = rst_n ? ready_int : 2'b00;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign busy       = (state_q != IDLE);

    alu #(.WIDTH(WIDTH)) u_alu (
        .a   (a_q),
        .b   (b_q),
        .op  (op_q),
        .cin (cin_q),
        .y   (alu_y)
    );

    // NOTE: the operand and result registers are reset too, so nothing from an
    // aborted operation is visible after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OP_INC;
            cin_q        <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            cin_q        <= cin_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
        end
    end

endmodule
